// File: rtl/multicycle_control.sv
// Multicycle CPU control unit: six-state fetch/decode/execute FSM driving the
// datapath enables and muxes, plus a retired-instruction counter.
module multicycle_control #(
   parameter int WORD_SIZE = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WORD_SIZE-1:0] instr,
   input  logic                 bcond,
   input  logic                 mem_ack,
   output logic [2:0]           state,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic                 i_or_d,
   output logic                 ir_write,
   output logic                 pc_write,
   output logic                 pc_write_cond,
   output logic                 reg_write,
   output logic [1:0]           pc_src,
   output logic [1:0]           imm_sel,
   output logic [1:0]           reg_dst,
   output logic [1:0]           wb_sel,
   output logic                 output_active,
   output logic                 is_halted,
   output logic [WORD_SIZE-1:0] num_inst
);

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5
   } state_t;

   state_t                 state_r;
   state_t                 next_s;
   logic                   retire_s;
   logic [WORD_SIZE-1:0]   num_inst_r;

   logic [3:0] op_s;
   logic [5:0] func_s;
   logic is_r_alu_s, is_alu_imm_s, is_lwd_s, is_swd_s, is_branch_s;
   logic is_jmp_s, is_jal_s, is_jpr_s, is_jrl_s, is_wwd_s, is_hlt_s, is_nop_s;

   // bcond gates the PC write inside the datapath; the controller only asserts pc_write_cond
   logic unused_s;
   assign unused_s = ^{bcond, instr[11:6]};

   assign op_s         = instr[15:12];
   assign func_s       = instr[5:0];
   assign is_r_alu_s   = (op_s == 4'd15) && (func_s <= 6'd7);
   assign is_alu_imm_s = (op_s == 4'd4) || (op_s == 4'd5) || (op_s == 4'd6);
   assign is_lwd_s     = (op_s == 4'd7);
   assign is_swd_s     = (op_s == 4'd8);
   assign is_branch_s  = (op_s <= 4'd3);
   assign is_jmp_s     = (op_s == 4'd9);
   assign is_jal_s     = (op_s == 4'd10);
   assign is_jpr_s     = (op_s == 4'd15) && (func_s == 6'd25);
   assign is_jrl_s     = (op_s == 4'd15) && (func_s == 6'd26);
   assign is_wwd_s     = (op_s == 4'd15) && (func_s == 6'd28);
   assign is_hlt_s     = (op_s == 4'd15) && (func_s == 6'd29);
   assign is_nop_s     = !(is_r_alu_s || is_alu_imm_s || is_lwd_s || is_swd_s || is_branch_s ||
                           is_jmp_s || is_jal_s || is_jpr_s || is_jrl_s || is_wwd_s || is_hlt_s);

   // State register and retired-instruction counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= S_IF;
         num_inst_r <= '0;
      end else begin
         state_r <= next_s;
         if (retire_s) begin
            num_inst_r <= num_inst_r + {{(WORD_SIZE-1){1'b0}}, 1'b1};
         end else begin
            num_inst_r <= num_inst_r;
         end
      end
   end

   // Next-state and control decode; all enables held low while reset is asserted
   always_comb begin
      next_s        = state_r;
      retire_s      = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      i_or_d        = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      reg_write     = 1'b0;
      pc_src        = 2'd0;
      reg_dst       = 2'd0;
      wb_sel        = 2'd0;
      output_active = 1'b0;
      if (reset) begin
         next_s = S_IF;
      end else begin
         case (state_r)
            S_IF: begin
               mem_read = 1'b1;
               if (mem_ack) begin
                  ir_write = 1'b1;
                  pc_write = 1'b1;
                  next_s   = S_ID;
               end else begin
                  next_s = S_IF;
               end
            end
            S_ID: begin
               if (is_hlt_s) begin
                  next_s = S_HALT;
               end else if (is_jmp_s || is_jal_s) begin
                  pc_write = 1'b1;
                  pc_src   = 2'd2;
                  next_s   = S_IF;
               end else if (is_jpr_s || is_jrl_s) begin
                  pc_write = 1'b1;
                  pc_src   = 2'd3;
                  next_s   = S_IF;
               end else if (is_nop_s) begin
                  next_s = S_IF;
               end else begin
                  next_s = S_EX;
               end
               if (is_jal_s || is_jrl_s) begin
                  reg_write = 1'b1;
                  reg_dst   = 2'd2;
                  wb_sel    = 2'd2;
               end else begin
                  reg_write = 1'b0;
               end
               retire_s = (next_s != S_EX);
            end
            S_EX: begin
               if (is_branch_s) begin
                  pc_write_cond = 1'b1;
                  pc_src        = 2'd1;
                  next_s        = S_IF;
               end else if (is_lwd_s || is_swd_s) begin
                  next_s = S_MEM;
               end else begin
                  next_s = S_WB;
               end
               retire_s = (next_s == S_IF);
            end
            S_MEM: begin
               i_or_d    = 1'b1;
               mem_read  = is_lwd_s;
               mem_write = is_swd_s;
               if (mem_ack) begin
                  next_s   = is_lwd_s ? S_WB : S_IF;
                  retire_s = !is_lwd_s;
               end else begin
                  next_s = S_MEM;
               end
            end
            S_WB: begin
               if (is_wwd_s) begin
                  output_active = 1'b1;
               end else begin
                  reg_write = 1'b1;
                  reg_dst   = is_r_alu_s ? 2'd1 : 2'd0;
                  wb_sel    = is_lwd_s ? 2'd1 : 2'd0;
               end
               next_s   = S_IF;
               retire_s = 1'b1;
            end
            S_HALT: begin
               next_s = S_HALT;
            end
            default: begin
               next_s = S_IF;
            end
         endcase
      end
   end

   // Immediate select depends only on opcode, so it is valid in every state
   always_comb begin
      case (op_s)
         4'd5, 4'd6: imm_sel = 2'd0;
         4'd9, 4'd10: imm_sel = 2'd2;
         default: imm_sel = 2'd1;
      endcase
   end

   assign state     = state_r;
   assign is_halted = (state_r == S_HALT);
   assign num_inst  = num_inst_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench: each stimulus cycle queues its expected output snapshot;
// a monitor pops and compares one snapshot per falling edge.
module tb_multicycle_control;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] instr;
   logic        bcond;
   logic        mem_ack;
   logic [2:0]  state;
   logic        mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, reg_write;
   logic [1:0]  pc_src, imm_sel, reg_dst, wb_sel;
   logic        output_active, is_halted;
   logic [15:0] num_inst;

   int checks = 0;
   int errors = 0;

   logic [35:0] exp_q[$];
   string       name_q[$];

   // enable order: {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, reg_write}
   localparam logic [6:0] E_NONE  = 7'b0000000;
   localparam logic [6:0] E_FETCH = 7'b1001100;
   localparam logic [6:0] E_FWAIT = 7'b1000000;
   localparam logic [6:0] E_LOAD  = 7'b1010000;
   localparam logic [6:0] E_STORE = 7'b0110000;
   localparam logic [6:0] E_BR    = 7'b0000010;
   localparam logic [6:0] E_JMP   = 7'b0000100;
   localparam logic [6:0] E_JAL   = 7'b0000101;
   localparam logic [6:0] E_WB    = 7'b0000001;

   multicycle_control #(.WORD_SIZE(16)) dut (
      .clk(clk), .reset(reset), .instr(instr), .bcond(bcond), .mem_ack(mem_ack),
      .state(state), .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
      .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
      .reg_write(reg_write), .pc_src(pc_src), .imm_sel(imm_sel), .reg_dst(reg_dst),
      .wb_sel(wb_sel), .output_active(output_active), .is_halted(is_halted),
      .num_inst(num_inst)
   );

   always #5 clk = ~clk;

   task automatic step(input logic r, input logic [15:0] ins, input logic bc, input logic ack,
                       input string nm, input logic [2:0] st, input logic [6:0] en,
                       input logic [1:0] pcs, input logic [1:0] im, input logic [1:0] rd,
                       input logic [1:0] wb, input logic oa, input logic hl,
                       input logic [15:0] ni);
      reset   = r;
      instr   = ins;
      bcond   = bc;
      mem_ack = ack;
      exp_q.push_back({st, en, pcs, im, rd, wb, oa, hl, ni});
      name_q.push_back(nm);
      @(posedge clk);
      #1;
   endtask

   // Monitor: one snapshot per falling edge whenever an expectation is pending
   initial begin
      logic [35:0] act;
      logic [35:0] exp_v;
      string       nm;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            act   = {state, mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
                     reg_write, pc_src, imm_sel, reg_dst, wb_sel, output_active, is_halted,
                     num_inst};
            checks++;
            if (act !== exp_v) begin
               errors++;
               $display("FAIL %s actual=%h expected=%h", nm, act, exp_v);
            end
         end
      end
   end

   initial begin
      reset = 1'b1; instr = 16'hF000; bcond = 1'b0; mem_ack = 1'b0;
      @(posedge clk);
      #1;
      step(1, 16'hF000, 0, 1, "reset",    3'd0, E_NONE,  2'd0, 2'd1, 2'd0, 2'd0, 0, 0, 16'd0);
      // ADD
      step(0, 16'hF000, 0, 1, "add_if",   3'd0, E_FETCH, 2'd0, 2'd1, 2'd0, 2'd0, 0, 0, 16'd0);
      step(0, 16'hF000, 0, 1, "add_id",   3'd1, E_NONE,  2'd0, 2'd1, 2'd0, 2'd0, 0, 0, 16'd0);
      step(0, 16'hF000, 0, 1, "add_ex",   3'd2, E_NONE,  2'd0, 2'd1, 2'd0, 2'd0, 0, 0, 16'd0);
      step(0, 16'hF000, 0, 1, "add_wb",   3'd4, E_WB,    2'd0, 2'd1, 2'd1, 2'd0, 0, 0, 16'd0);
      // LWD, ack delayed three cycles in MEM
      step(0, 16'h7000, 0, 1, "lwd_if",   3'd0, E_FETCH, 2'd0, 2'd1, 2'd0, 2'd0, 0, 0, 16'd1);
      step(0, 16'h7000, 0, 1, "lwd_id",   3'd1, E_NONE,  2'd0, 2'd1, 2'd0, 2'd0, 0, 0, 16'd1);
      step(0, 16'h7000, 0, 1, "lwd_ex",   3'd2, E_NONE,  2'd0, 2'd1, 2'd0, 2'd0, 0, 0, 16'd1);
      for (int i = 0; i < 3; i++)
         step(0, 16'h7000, 0, 0, "lwd_memw", 3'd3, E_LOAD, 2'd0, 2'd1, 2'd0, 2'd0, 0, 0, 16'd1);
      step(0, 16'h7000, 0, 1, "lwd_mem",  3'd3, E_LOAD,  2'd0, 2'd1, 2'd0, 2'd0, 0, 0, 16'd1);
      step(0, 16'h7000, 0, 1, "lwd_wb",   3'd4, E_WB,    2'd0, 2'd1, 2'd0, 2'd1, 0, 0, 16'd1);
      // BEQ not taken, then taken: same control, two retirements
      for (int i = 0; i < 2; i++) begin
         step(0, 16'h1000, i[0], 1, "beq_if", 3'd0, E_FETCH, 2'd0, 2'd1, 2'd0, 2'd0, 0, 0, 16'(2 + i));
         step(0, 16'h1000, i[0], 1, "beq_id", 3'd1, E_NONE,  2'd0, 2'd1, 2'd0, 2'd0, 0, 0, 16'(2 + i));
         step(0, 16'h1000, i[0], 1, "beq_ex", 3'd2, E_BR,    2'd1, 2'd1, 2'd0, 2'd0, 0, 0, 16'(2 + i));
      end
      // JAL
      step(0, 16'hA123, 0, 1, "jal_if",   3'd0, E_FETCH, 2'd0, 2'd2, 2'd0, 2'd0, 0, 0, 16'd4);
      step(0, 16'hA123, 0, 1, "jal_id",   3'd1, E_JAL,   2'd2, 2'd2, 2'd2, 2'd2, 0, 0, 16'd4);
      // JPR
      step(0, 16'hF019, 0, 1, "jpr_if",   3'd0, E_FETCH, 2'd0, 2'd1, 2'd0, 2'd0, 0, 0, 16'd5);
      step(0, 16'hF019, 0, 1, "jpr_id",   3'd1, E_JMP,   2'd3, 2'd1, 2'd0, 2'd0, 0, 0, 16'd5);
      // NOP (opcode 11)
      step(0, 16'hB000, 0, 1, "nop_if",   3'd0, E_FETCH, 2'd0, 2'd1, 2'd0, 2'd0, 0, 0, 16'd6);
      step(0, 16'hB000, 0, 1, "nop_id",   3'd1, E_NONE,  2'd0, 2'd1, 2'd0, 2'd0, 0, 0, 16'd6);
      // ORI
      step(0, 16'h5000, 0, 1, "ori_if",   3'd0, E_FETCH, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 16'd7);
      step(0, 16'h5000, 0, 1, "ori_id",   3'd1, E_NONE,  2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 16'd7);
      step(0, 16'h5000, 0, 1, "ori_ex",   3'd2, E_NONE,  2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 16'd7);
      step(0, 16'h5000, 0, 1, "ori_wb",   3'd4, E_WB,    2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 16'd7);
      // WWD
      step(0, 16'hF01C, 0, 1, "wwd_if",   3'd0, E_FETCH, 2'd0, 2'd1, 2'd0, 2'd0, 0, 0, 16'd8);
      step(0, 16'hF01C, 0, 1, "wwd_id",   3'd1, E_NONE,  2'd0, 2'd1, 2'd0, 2'd0, 0, 0, 16'd8);
      step(0, 16'hF01C, 0, 1, "wwd_ex",   3'd2, E_NONE,  2'd0, 2'd1, 2'd0, 2'd0, 0, 0, 16'd8);
      step(0, 16'hF01C, 0, 1, "wwd_wb",   3'd4, E_NONE,  2'd0, 2'd1, 2'd0, 2'd0, 1, 0, 16'd8);
      // SWD with one fetch wait cycle
      step(0, 16'h8000, 0, 0, "swd_ifw",  3'd0, E_FWAIT, 2'd0, 2'd1, 2'd0, 2'd0, 0, 0, 16'd9);
      step(0, 16'h8000, 0, 1, "swd_if",   3'd0, E_FETCH, 2'd0, 2'd1, 2'd0, 2'd0, 0, 0, 16'd9);
      step(0, 16'h8000, 0, 1, "swd_id",   3'd1, E_NONE,  2'd0, 2'd1, 2'd0, 2'd0, 0, 0, 16'd9);
      step(0, 16'h8000, 0, 1, "swd_ex",   3'd2, E_NONE,  2'd0, 2'd1, 2'd0, 2'd0, 0, 0, 16'd9);
      step(0, 16'h8000, 0, 1, "swd_mem",  3'd3, E_STORE, 2'd0, 2'd1, 2'd0, 2'd0, 0, 0, 16'd9);
      // SWD interrupted by reset mid-MEM
      step(0, 16'h8000, 0, 1, "swd2_if",  3'd0, E_FETCH, 2'd0, 2'd1, 2'd0, 2'd0, 0, 0, 16'd10);
      step(0, 16'h8000, 0, 1, "swd2_id",  3'd1, E_NONE,  2'd0, 2'd1, 2'd0, 2'd0, 0, 0, 16'd10);
      step(0, 16'h8000, 0, 1, "swd2_ex",  3'd2, E_NONE,  2'd0, 2'd1, 2'd0, 2'd0, 0, 0, 16'd10);
      step(0, 16'h8000, 0, 0, "swd2_mem", 3'd3, E_STORE, 2'd0, 2'd1, 2'd0, 2'd0, 0, 0, 16'd10);
      step(1, 16'h8000, 0, 1, "swd2_rst", 3'd0, E_NONE,  2'd0, 2'd1, 2'd0, 2'd0, 0, 0, 16'd0);
      step(1, 16'h8000, 0, 1, "rst_hold", 3'd0, E_NONE,  2'd0, 2'd1, 2'd0, 2'd0, 0, 0, 16'd0);
      // HLT, then mem_ack toggling must change nothing
      step(0, 16'hF01D, 0, 1, "hlt_if",   3'd0, E_FETCH, 2'd0, 2'd1, 2'd0, 2'd0, 0, 0, 16'd0);
      step(0, 16'hF01D, 0, 1, "hlt_id",   3'd1, E_NONE,  2'd0, 2'd1, 2'd0, 2'd0, 0, 0, 16'd0);
      for (int i = 0; i < 10; i++)
         step(0, 16'hF01D, 0, i[0], "halt",  3'd5, E_NONE, 2'd0, 2'd1, 2'd0, 2'd0, 0, 1, 16'd1);
      step(1, 16'hF01D, 0, 1, "halt_rst", 3'd0, E_NONE,  2'd0, 2'd1, 2'd0, 2'd0, 0, 0, 16'd0);
      step(0, 16'hF01D, 0, 1, "post_if",  3'd0, E_FETCH, 2'd0, 2'd1, 2'd0, 2'd0, 0, 0, 16'd0);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
